// File: rtl/mmd_divnum_ctrl_pkg.sv
// Shared constants, MASH order encoding and the DIVNUM clamp helper for the
// MMD divide-ratio sequencer.
package mmd_pkg;
  localparam int DIVNUM_W = 6;
  localparam int DIV_MIN  = 4;
  localparam int DIV_MAX  = 63;

  typedef enum logic [1:0] {ORD_INT, ORD_1, ORD_2, ORD_3} mash_ord_t;

  function automatic logic [DIVNUM_W-1:0] clamp_div(input logic signed [7:0] s,
                                                    input logic signed [7:0] lo,
                                                    input logic signed [7:0] hi);
    logic signed [7:0] t;
    t = (s < lo) ? lo : ((s > hi) ? hi : s);
    return DIVNUM_W'(t);
  endfunction
endpackage

// File: rtl/mmd_divnum_ctrl_if.sv
// Config/handshake/ratio bundle between the sequencer and its controller.
interface mmd_divnum_ctrl_if #(parameter int FRAC_W = 16);
  logic              EN;
  logic [5:0]        NINT;
  logic [FRAC_W-1:0] NFRAC;
  logic [1:0]        MASH_ORD;
  logic              CFG_REQ;
  logic              CFG_ACK;
  logic [5:0]        DIVNUM;
  logic              CLAMP;

  modport master (output EN, NINT, NFRAC, MASH_ORD, CFG_REQ,
                  input  CFG_ACK, DIVNUM, CLAMP);
  modport slave  (input  EN, NINT, NFRAC, MASH_ORD, CFG_REQ,
                  output CFG_ACK, DIVNUM, CLAMP);
endinterface

// File: rtl/mmd_divnum_ctrl_acc.sv
// One MASH accumulator stage: modulo-2^W register with hold, clear and a
// combinational carry/sum taken from the value being written this edge.
module mmd_acc_stage #(
  parameter int W = 16
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_en,
  input  logic         i_clr,
  input  logic [W-1:0] i_addend,
  output logic [W-1:0] o_sum,
  output logic         o_carry
);
  logic [W-1:0] r_acc;
  logic [W:0]   w_sum;

  assign w_sum   = {1'b0, r_acc} + {1'b0, i_addend};
  assign o_sum   = w_sum[W-1:0];
  assign o_carry = w_sum[W];

  always_ff @(posedge i_clk) begin
    if (i_rst || i_clr) r_acc <= '0;
    else if (i_en)      r_acc <= w_sum[W-1:0];
  end
endmodule

// File: rtl/mmd_divnum_ctrl.sv
// Fractional-N DIVNUM sequencer: REQ/ACK config load, MASH 1-1-1 noise
// shaping of the integer ratio and clamping to the MMD range.
module mmd_divnum_ctrl #(
  parameter int FRAC_W  = 16,
  parameter int DIV_MIN = mmd_pkg::DIV_MIN,
  parameter int DIV_MAX = mmd_pkg::DIV_MAX
) (
  input  logic               CKVD,
  input  logic               RST,
  mmd_divnum_ctrl_if.slave   bus
);
  import mmd_pkg::*;

  localparam logic signed [7:0] LO = 8'(DIV_MIN);
  localparam logic signed [7:0] HI = 8'(DIV_MAX);

  logic [5:0]        r_nint_a;
  logic [FRAC_W-1:0] r_nfrac_a;
  mash_ord_t         r_ord_a;
  logic              r_ack, r_clamp;
  logic              r_c2_d, r_c3_d, r_c3_dd;
  logic [5:0]        r_divnum;

  logic              w_load;
  logic              w_c1, w_c2, w_c3;
  logic [FRAC_W-1:0] w_s1, w_s2, w_unused_s3;
  logic signed [7:0] w_e1, w_e2, w_e2d, w_e3, w_e3d, w_e3dd;
  logic signed [7:0] w_y, w_s;
  logic              w_oor;

  // A load is the rising phase of the handshake only; ACK high blocks repeats.
  assign w_load = bus.CFG_REQ & ~r_ack;

  mmd_acc_stage #(.W(FRAC_W)) u_acc1 (
    .i_clk(CKVD), .i_rst(RST), .i_en(bus.EN), .i_clr(w_load),
    .i_addend(r_nfrac_a), .o_sum(w_s1), .o_carry(w_c1));
  mmd_acc_stage #(.W(FRAC_W)) u_acc2 (
    .i_clk(CKVD), .i_rst(RST), .i_en(bus.EN), .i_clr(w_load),
    .i_addend(w_s1), .o_sum(w_s2), .o_carry(w_c2));
  mmd_acc_stage #(.W(FRAC_W)) u_acc3 (
    .i_clk(CKVD), .i_rst(RST), .i_en(bus.EN), .i_clr(w_load),
    .i_addend(w_s2), .o_sum(w_unused_s3), .o_carry(w_c3));

  assign w_e1   = {7'd0, w_c1};
  assign w_e2   = {7'd0, w_c2};
  assign w_e2d  = {7'd0, r_c2_d};
  assign w_e3   = {7'd0, w_c3};
  assign w_e3d  = {7'd0, r_c3_d};
  assign w_e3dd = {7'd0, r_c3_dd};

  always_comb begin
    w_y = '0;
    case (r_ord_a)
      ORD_1:   w_y = w_e1;
      ORD_2:   w_y = w_e1 + w_e2 - w_e2d;
      ORD_3:   w_y = w_e1 + w_e2 - w_e2d + w_e3 - (w_e3d <<< 1) + w_e3dd;
      default: w_y = '0;
    endcase
  end

  // Load edge uses the incoming ratio directly; y is zero since accs clear.
  always_comb begin
    w_s = {2'b00, r_nint_a};
    if (w_load)      w_s = {2'b00, bus.NINT};
    else if (bus.EN) w_s = {2'b00, r_nint_a} + w_y;
  end

  assign w_oor = (w_s < LO) || (w_s > HI);

  always_ff @(posedge CKVD) begin
    if (RST) begin
      r_nint_a  <= 6'd4;
      r_nfrac_a <= '0;
      r_ord_a   <= ORD_INT;
      r_ack     <= 1'b0;
      r_clamp   <= 1'b0;
      r_c2_d    <= 1'b0;
      r_c3_d    <= 1'b0;
      r_c3_dd   <= 1'b0;
      r_divnum  <= 6'd4;
    end else if (w_load) begin
      r_nint_a  <= bus.NINT;
      r_nfrac_a <= bus.NFRAC;
      r_ord_a   <= mash_ord_t'(bus.MASH_ORD);
      r_ack     <= 1'b1;
      r_clamp   <= w_oor;
      r_c2_d    <= 1'b0;
      r_c3_d    <= 1'b0;
      r_c3_dd   <= 1'b0;
      r_divnum  <= clamp_div(w_s, LO, HI);
    end else begin
      if (!bus.CFG_REQ) r_ack <= 1'b0;
      if (bus.EN) begin
        r_c2_d  <= w_c2;
        r_c3_d  <= w_c3;
        r_c3_dd <= r_c3_d;
      end
      if (w_oor) r_clamp <= 1'b1;
      r_divnum <= clamp_div(w_s, LO, HI);
    end
  end

  assign bus.CFG_ACK = r_ack;
  assign bus.DIVNUM  = r_divnum;
  assign bus.CLAMP   = r_clamp;
endmodule

// File: tb/tb_mmd_divnum_ctrl.sv
// Directed bench for mmd_divnum_ctrl with a small reference model of the
// modulator used for the pause/resume sequence.
module tb_mmd_divnum_ctrl;
  logic CKVD = 1'b0;
  logic RST  = 1'b1;

  mmd_divnum_ctrl_if #(.FRAC_W(16)) bus ();

  mmd_divnum_ctrl #(.FRAC_W(16), .DIV_MIN(4), .DIV_MAX(63)) dut (
    .CKVD(CKVD), .RST(RST), .bus(bus));

  always #5 CKVD = ~CKVD;

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  // Reference model state
  int m_nint = 4, m_nfrac = 0, m_ord = 0;
  int m_a1 = 0, m_a2 = 0, m_a3 = 0;
  int m_c2d = 0, m_c3d = 0, m_c3dd = 0;
  int m_ack = 0, m_div = 4, m_clamp = 0;

  function automatic int mclamp(input int s);
    return (s < 4) ? 4 : ((s > 63) ? 63 : s);
  endfunction

  task automatic model_step();
    int a1, a2, a3, c1, c2, c3, y, s;
    if (RST) begin
      m_nint = 4; m_nfrac = 0; m_ord = 0;
      m_a1 = 0; m_a2 = 0; m_a3 = 0; m_c2d = 0; m_c3d = 0; m_c3dd = 0;
      m_ack = 0; m_div = 4; m_clamp = 0;
    end else if (bus.CFG_REQ && m_ack == 0) begin
      m_nint = int'(bus.NINT); m_nfrac = int'(bus.NFRAC); m_ord = int'(bus.MASH_ORD);
      m_a1 = 0; m_a2 = 0; m_a3 = 0; m_c2d = 0; m_c3d = 0; m_c3dd = 0;
      m_ack = 1; m_div = mclamp(m_nint);
      m_clamp = (m_nint < 4 || m_nint > 63) ? 1 : 0;
    end else begin
      if (!bus.CFG_REQ) m_ack = 0;
      s = m_nint;
      if (bus.EN) begin
        a1 = m_a1 + m_nfrac; c1 = a1 >> 16; a1 = a1 & 65535;
        a2 = m_a2 + a1;      c2 = a2 >> 16; a2 = a2 & 65535;
        a3 = m_a3 + a2;      c3 = a3 >> 16; a3 = a3 & 65535;
        case (m_ord)
          1:       y = c1;
          2:       y = c1 + c2 - m_c2d;
          3:       y = c1 + c2 - m_c2d + c3 - 2 * m_c3d + m_c3dd;
          default: y = 0;
        endcase
        s = s + y;
        m_c3dd = m_c3d; m_c3d = c3; m_c2d = c2;
        m_a1 = a1; m_a2 = a2; m_a3 = a3;
      end
      m_div = mclamp(s);
      if (s < 4 || s > 63) m_clamp = 1;
    end
  endtask

  task automatic tick();
    @(posedge CKVD);
    model_step();
    #1;
  endtask

  task automatic do_load(input int nint, input int nfrac, input int ord);
    bus.NINT     = 6'(nint);
    bus.NFRAC    = 16'(nfrac);
    bus.MASH_ORD = 2'(ord);
    bus.CFG_REQ  = 1'b1;
    tick();
  endtask

  initial begin
    int bad, sum, vmin, vmax, d;
    bus.EN = 1'b0; bus.NINT = '0; bus.NFRAC = '0; bus.MASH_ORD = '0; bus.CFG_REQ = 1'b0;
    tick(); tick();
    chk("rst_divnum", int'(bus.DIVNUM), 4);
    chk("rst_ack", int'(bus.CFG_ACK), 0);
    chk("rst_clamp", int'(bus.CLAMP), 0);
    RST = 1'b0;

    // Idle: no request ever
    bad = 0;
    for (int i = 0; i < 100; i++) begin
      tick();
      if (bus.DIVNUM != 6'd4 || bus.CLAMP || bus.CFG_ACK) bad++;
    end
    chk("idle_bad_cycles", bad, 0);

    // Order 1, half fraction: 10, 10, 11, 10, 11 ...
    bus.EN = 1'b1;
    do_load(10, 'h8000, 1);
    chk("o1_load_div", int'(bus.DIVNUM), 10);
    chk("o1_load_ack", int'(bus.CFG_ACK), 1);
    bus.CFG_REQ = 1'b0;
    sum = 0; bad = 0;
    for (int i = 1; i <= 1024; i++) begin
      tick();
      sum += int'(bus.DIVNUM);
      if (int'(bus.DIVNUM) != ((i % 2 == 0) ? 11 : 10)) bad++;
      if (i == 1) chk("o1_ack_drop", int'(bus.CFG_ACK), 0);
      if (i == 2) chk("o1_edge2", int'(bus.DIVNUM), 11);
    end
    chk("o1_pattern_bad", bad, 0);
    chk("o1_sum1024", sum, 10752);

    // Order 3, quarter fraction: bounded, exact mean over full period
    do_load(20, 'h4000, 3);
    chk("o3_load_div", int'(bus.DIVNUM), 20);
    bus.CFG_REQ = 1'b0;
    sum = 0; bad = 0;
    for (int i = 1; i <= 65536; i++) begin
      tick();
      d = int'(bus.DIVNUM);
      sum += d;
      if (d < 17 || d > 24) bad++;
    end
    chk("o3_range_bad", bad, 0);
    chk("o3_sum65536", sum, 1327104);
    chk("o3_clamp", int'(bus.CLAMP), 0);

    // Top of range: clamp engages, never below 62-3
    do_load(62, 'hFFFF, 3);
    bus.CFG_REQ = 1'b0;
    vmin = 99; vmax = 0;
    for (int i = 0; i < 200; i++) begin
      tick();
      d = int'(bus.DIVNUM);
      if (d < vmin) vmin = d;
      if (d > vmax) vmax = d;
    end
    chk("hi_max", vmax, 63);
    chk("hi_min_ge59", (vmin >= 59) ? 1 : 0, 1);
    chk("hi_clamp", int'(bus.CLAMP), 1);

    // Integer reload clears sticky clamp
    do_load(30, 0, 0);
    chk("int_load_clamp", int'(bus.CLAMP), 0);
    bus.CFG_REQ = 1'b0;
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (bus.DIVNUM != 6'd30) bad++;
    end
    chk("int_const_bad", bad, 0);
    chk("int_clamp", int'(bus.CLAMP), 0);

    // Handshake: REQ high 5 edges, NINT changed while ACK high
    bus.NINT = 6'd12; bus.MASH_ORD = 2'd0; bus.CFG_REQ = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk($sformatf("hs_ack_%0d", i), int'(bus.CFG_ACK), 1);
      chk($sformatf("hs_div_%0d", i), int'(bus.DIVNUM), 12);
      bus.NINT = 6'd40;
    end
    bus.CFG_REQ = 1'b0;
    tick();
    chk("hs_ack_fall", int'(bus.CFG_ACK), 0);
    chk("hs_div_fall", int'(bus.DIVNUM), 12);
    tick();
    chk("hs_no_reload", int'(bus.DIVNUM), 12);

    // Pause/resume against the reference model, order 2
    do_load(16, 'h3333, 2);
    bus.CFG_REQ = 1'b0;
    for (int i = 0; i < 100; i++) begin
      tick();
      chk("en_run_a", int'(bus.DIVNUM), m_div);
    end
    bus.EN = 1'b0;
    for (int i = 0; i < 50; i++) begin
      tick();
      chk("en_hold", int'(bus.DIVNUM), 16);
    end
    bus.EN = 1'b1;
    for (int i = 0; i < 100; i++) begin
      tick();
      chk("en_run_b", int'(bus.DIVNUM), m_div);
    end

    // Reset in the middle of a handshake, then automatic reload
    do_load(25, 0, 0);
    chk("rh_load", int'(bus.DIVNUM), 25);
    RST = 1'b1;
    tick();
    chk("rh_rst_div", int'(bus.DIVNUM), 4);
    chk("rh_rst_ack", int'(bus.CFG_ACK), 0);
    chk("rh_rst_clamp", int'(bus.CLAMP), 0);
    RST = 1'b0;
    tick();
    chk("rh_reload_ack", int'(bus.CFG_ACK), 1);
    chk("rh_reload_div", int'(bus.DIVNUM), 25);
    bus.CFG_REQ = 1'b0;
    tick();
    chk("rh_ack_fall", int'(bus.CFG_ACK), 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/mmd_divnum_ctrl.md
# mmd_divnum_ctrl

Fractional-N divide-ratio sequencer for the 5-stage multi-modulus divider (MMD).
- Runs in the divided-clock domain (CKVD).
- Each CKVD cycle it emits a new 6-bit DIVNUM = integer ratio + MASH 1-1-1 delta-sigma offset, which the MMD retimes at its own CKVD rising edge.
- Programmable MASH order (0–3), clamping to the MMD range 4–63, and a four-phase REQ/ACK handshake for atomic reconfiguration.

## Interface
Parameters:
- FRAC_W, 16, fractional word / accumulator width
- DIV_MIN, 4, lowest legal DIVNUM
- DIV_MAX, 63, highest legal DIVNUM

Ports:
- CKVD  input  1  clock: divided clock from the MMD; all logic on its rising edge
- RST  input  1  reset; synchronous, active-high
- EN  input  1  modulator enable
- NINT  input  6  requested integer ratio
- NFRAC  input  FRAC_W  requested fractional ratio, unsigned, NFRAC/2^FRAC_W
- MASH_ORD  input  2  requested order: 0 = integer, 1, 2, 3
- CFG_REQ  input  1  config-load request, level
- CFG_ACK  output  1  config-load acknowledge, level
- DIVNUM  output  6  ratio to the MMD, registered
- CLAMP  output  1  sticky: a DIVNUM was clamped since the last load

## Operation
- Active config registers nint_a, nfrac_a, ord_a. Reset values: 4, 0, 0.
- Load rule: CFG_REQ & ~CFG_ACK at an edge causes all of the following on that edge:
  - copy NINT/NFRAC/MASH_ORD into the active registers
  - clear acc1..acc3 and carry history
  - clear CLAMP
  - set CFG_ACK
- CFG_ACK stays high while CFG_REQ is high. It drops on the first edge that samples CFG_REQ low.
- A new load needs REQ low → high again. The load ignores EN.
- Accumulator stages, each FRAC_W bits, unsigned modulo 2^FRAC_W:
  - acc1' = acc1 + nfrac_a, carry c1
  - acc2' = acc2 + acc1', carry c2
  - acc3' = acc3 + acc2', carry c3
  - Carry history: c2_d, c3_d, c3_dd.
- Offset y (signed 4-bit):
  - ord 0: y = 0
  - ord 1: y = c1
  - ord 2: y = c1 + c2 − c2_d, range −1..2
  - ord 3: y = c1 + c2 − c2_d + c3 − 2·c3_d + c3_dd, range −3..4
- Sum s = nint_a + y, computed at 8 bits signed.
- DIVNUM = min(max(s, DIV_MIN), DIV_MAX). If s is outside the range, set CLAMP.
- EN low:
  - accumulators and carry history hold
  - DIVNUM = clamp(nint_a), y forced to 0
  - CLAMP still updates
- EN high resumes from the held state.

## Timing
- Reset values: DIVNUM = 4, CFG_ACK = 0, CLAMP = 0; all accumulators and history 0.
- DIVNUM is updated on every CKVD edge with EN = 1. The value uses the accumulator results computed on that same edge (carries are combinational from the current sums). Latency input-state → DIVNUM is one register.
- The MMD samples DIVNUM at its next CKVD rising edge, so each value governs exactly one divided period.
- Load edge:
  - DIVNUM on that edge already uses the new nint_a with y = 0, since accumulators are cleared.
  - Modulation restarts on the following edge.
- Reset during handshake: CFG_ACK drops to 0. If CFG_REQ is still high, the load repeats on the first edge after reset deasserts.
- Accumulator wrap is silent; it is the intended carry mechanism.

## Structure
- Shared package mmd_pkg holds:
  - DIVNUM_W = 6, DIV_MIN = 4, DIV_MAX = 63
  - typedef enum mash_ord_t {ORD_INT, ORD_1, ORD_2, ORD_3}
  - clamp function on signed 8-bit → 6-bit
- One sub-module, mmd_acc_stage: FRAC_W-bit registered accumulator with hold (EN), clear, and carry-out. Instantiated three times and chained.
- Handshake, noise-shaping sum and clamp stay in the top.

## Test plan
- Reset, REQ never asserted → DIVNUM = 4, CLAMP = 0, CFG_ACK = 0 for 100 cycles.
- Load NINT = 10, NFRAC = 0x8000, ord 1, EN = 1 → load edge gives 10, then 10, 11, 10, 11…; mean exactly 10.5 over 1024 cycles.
- Load NINT = 20, NFRAC = 0x4000, ord 3 → every DIVNUM in 17..24; sum over 65536 cycles = 20.25·65536; CLAMP = 0.
- Load NINT = 62, NFRAC = 0xFFFF, ord 3 → no DIVNUM > 63, CLAMP = 1. Reload NINT = 30, ord 0 → CLAMP = 0, DIVNUM = 30 constant.
- Handshake:
  - REQ held high 5 cycles → exactly one load, ACK high from the load edge until one edge after REQ falls.
  - Change NINT while ACK is high → no effect.
- EN low for 50 cycles mid-modulation (ord 2) → DIVNUM = nint_a constant. On EN high the sequence continues identically to a golden model paused at the same point.
- RST pulsed while ACK = 1 and REQ = 1 → outputs return to reset values, then reload on the first post-reset edge.
